pdl_ptr_buf: RTL and testbench

//  Pointer/index registers and storage for the 1024-word PDL buffer; responder side of PDL control.

---
 rtl/pdl_ptr_buf.sv | 117 +++++++++++
 tb/tb_pdl_ptr_buf.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pdl_ptr_buf.sv
// PDL buffer: pointer/index registers, 2-stage write path, synchronous read
// with pending-write bypass, and MF bus readback of pointer/index.
module pdl_ptr_buf #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              state_alu,
    input  logic              state_write,
    input  logic              state_fetch,
    input  logic              state_read,
    input  logic [ADDR_W-1:0] pdla,
    input  logic              pwp,
    input  logic              prp,
    input  logic              pdlcnt,
    input  logic              destpdl_p,
    input  logic              destpdlp,
    input  logic              destpdlx,
    input  logic              srcpdlptr,
    input  logic              srcpdlidx,
    input  logic [DATA_W-1:0] ob,
    output logic [ADDR_W-1:0] pdlptr,
    output logic [ADDR_W-1:0] pdlidx,
    output logic [DATA_W-1:0] pdl,
    output logic [DATA_W-1:0] mf,
    output logic              mfdrive
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ONE = 1;

    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] pdl_q, pdl_d;
    logic              pend_q, pend_d;
    logic              wr_cap;
    logic              rd_en;

    logic [DATA_W-1:0] mem [DEPTH];

    assign wr_cap = state_write & pwp;
    assign rd_en  = state_read & prp;

    // Explicit loads take priority over push/pop counting.
    always_comb begin
        ptr_d = ptr_q;
        idx_d = idx_q;
        if (state_fetch) begin
            if (destpdlp) begin
                ptr_d = ob[ADDR_W-1:0];
            end else if (pdlcnt) begin
                ptr_d = destpdl_p ? ptr_q + ONE : ptr_q - ONE;
            end
            if (destpdlx) begin
                idx_d = ob[ADDR_W-1:0];
            end
        end
    end

    always_comb begin
        pend_d  = wr_cap;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        pdl_d   = pdl_q;
        if (wr_cap) begin
            waddr_d = pdla;
            wdata_d = ob;
        end
        // A write still sitting in the pending register is newer than RAM.
        if (rd_en) begin
            pdl_d = (pend_q && waddr_q == pdla) ? wdata_q : mem[pdla];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q   <= '0;
            idx_q   <= '0;
            pend_q  <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            pdl_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            pdl_q   <= pdl_d;
        end
    end

    always_ff @(posedge clk) begin
        if (pend_q && !reset) begin
            mem[waddr_q] <= wdata_q;
        end
    end

    assign mfdrive = (srcpdlptr | srcpdlidx)
                   & (state_alu | state_write | state_fetch);

    always_comb begin
        mf = '0;
        if (mfdrive) begin
            mf = srcpdlptr ? {{(DATA_W-ADDR_W){1'b0}}, ptr_q}
                           : {{(DATA_W-ADDR_W){1'b0}}, idx_q};
        end
    end

    assign pdlptr = ptr_q;
    assign pdlidx = idx_q;
    assign pdl    = pdl_q;

endmodule

// File: tb/tb_pdl_ptr_buf.sv
// Bench for pdl_ptr_buf: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_pdl_ptr_buf;

    logic        clk = 1'b0;
    logic        reset;
    logic        state_alu, state_write, state_fetch, state_read;
    logic [9:0]  pdla;
    logic        pwp, prp, pdlcnt, destpdl_p, destpdlp, destpdlx;
    logic        srcpdlptr, srcpdlidx;
    logic [31:0] ob;
    logic [9:0]  pdlptr, pdlidx;
    logic [31:0] pdl, mf;
    logic        mfdrive;

    int n_cmp = 0;
    int n_err = 0;
    bit run   = 0;

    // model state
    int          m_ptr, m_idx;
    logic [31:0] m_pdl;
    bit          m_pdl_known;
    logic [31:0] m_mem [1024];
    bit          m_known [1024];
    bit          m_pend;
    int          m_paddr;
    logic [31:0] m_pdata;

    always #5 clk = ~clk;

    pdl_ptr_buf dut (
        .clk(clk), .reset(reset),
        .state_alu(state_alu), .state_write(state_write),
        .state_fetch(state_fetch), .state_read(state_read),
        .pdla(pdla), .pwp(pwp), .prp(prp), .pdlcnt(pdlcnt),
        .destpdl_p(destpdl_p), .destpdlp(destpdlp), .destpdlx(destpdlx),
        .srcpdlptr(srcpdlptr), .srcpdlidx(srcpdlidx), .ob(ob),
        .pdlptr(pdlptr), .pdlidx(pdlidx), .pdl(pdl),
        .mf(mf), .mfdrive(mfdrive)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic clr();
        reset = 0; state_alu = 0; state_write = 0; state_fetch = 0;
        state_read = 0; pdla = '0; pwp = 0; prp = 0; pdlcnt = 0;
        destpdl_p = 0; destpdlp = 0; destpdlx = 0; srcpdlptr = 0;
        srcpdlidx = 0; ob = '0;
    endtask

    task automatic do_rst();
        @(negedge clk); clr(); reset = 1;
    endtask

    task automatic fetch(input bit cnt, input bit push, input bit ldp,
                         input bit ldx, input logic [31:0] v);
        @(negedge clk); clr(); state_fetch = 1; pdlcnt = cnt;
        destpdl_p = push; destpdlp = ldp; destpdlx = ldx; ob = v;
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk); clr(); state_write = 1; pwp = 1; pdla = a; ob = d;
    endtask

    task automatic rd(input logic [9:0] a);
        @(negedge clk); clr(); state_read = 1; prp = 1; pdla = a;
    endtask

    task automatic idle();
        @(negedge clk); clr(); #3;
    endtask

    // Behavioural model: a read sees the newest write captured in any
    // earlier cycle unless a reset intervened before that write landed.
    always @(posedge clk) begin
        if (reset) begin
            m_ptr = 0; m_idx = 0; m_pdl = 0; m_pdl_known = 1;
            m_pend = 0;
            foreach (m_known[i]) m_known[i] = 0;
        end else begin
            if (state_fetch) begin
                if (destpdlp) m_ptr = ob % 1024;
                else if (pdlcnt) m_ptr = (m_ptr + (destpdl_p ? 1 : 1023)) % 1024;
                if (destpdlx) m_idx = ob % 1024;
            end
            if (state_read && prp) begin
                if (m_pend && m_paddr == int'(pdla)) begin
                    m_pdl = m_pdata; m_pdl_known = 1;
                end else begin
                    m_pdl = m_mem[pdla]; m_pdl_known = m_known[pdla];
                end
            end
            if (m_pend) begin
                m_mem[m_paddr] = m_pdata; m_known[m_paddr] = 1; m_pend = 0;
            end
            if (state_write && pwp) begin
                m_pend = 1; m_paddr = int'(pdla); m_pdata = ob;
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (run) begin
            logic        e_drv;
            logic [31:0] e_mf;
            e_drv = (srcpdlptr | srcpdlidx)
                  & (state_alu | state_write | state_fetch);
            e_mf  = !e_drv ? 32'd0 : srcpdlptr ? m_ptr : m_idx;
            chk("m_ptr", {22'd0, pdlptr}, m_ptr);
            chk("m_idx", {22'd0, pdlidx}, m_idx);
            chk("m_mfdrive", {31'd0, mfdrive}, {31'd0, e_drv});
            chk("m_mf", mf, e_mf);
            if (m_pdl_known) chk("m_pdl", pdl, m_pdl);
        end
    end

    initial begin
        clr();
        do_rst();
        idle();
        run = 1;
        chk("rst_ptr", {22'd0, pdlptr}, 32'd0);
        chk("rst_idx", {22'd0, pdlidx}, 32'd0);
        chk("rst_pdl", pdl, 32'd0);
        chk("rst_mfdrive", {31'd0, mfdrive}, 32'd0);

        // T1 pushes
        for (int i = 1; i <= 3; i++) begin
            fetch(1, 1, 0, 0, 0); idle();
            chk("t1_push", {22'd0, pdlptr}, i);
        end
        // T2 wrap both ways
        fetch(0, 0, 1, 0, 32'h3FF); idle();
        chk("t2_load", {22'd0, pdlptr}, 32'd1023);
        fetch(1, 1, 0, 0, 0); idle();
        chk("t2_wrap_up", {22'd0, pdlptr}, 32'd0);
        fetch(1, 0, 0, 0, 0); idle();
        chk("t2_wrap_dn", {22'd0, pdlptr}, 32'd1023);
        // T3 load beats count
        fetch(1, 0, 1, 0, 32'h10); idle();
        chk("t3_ld_beats_cnt", {22'd0, pdlptr}, 32'h10);
        // T4 commit path then bypass path
        wr(5, 32'hDEADBEEF); idle(); rd(5); idle();
        chk("t4_commit", pdl, 32'hDEADBEEF);
        wr(5, 32'h12345678); rd(5); idle();
        chk("t4_bypass", pdl, 32'h12345678);
        rd(5); idle();
        chk("t4_after_bypass", pdl, 32'h12345678);
        // T5 MF readback
        fetch(0, 0, 0, 1, 32'hFFFF_F2A5); idle();
        @(negedge clk); clr(); state_alu = 1; srcpdlidx = 1; #3;
        chk("t5_mfdrive", {31'd0, mfdrive}, 32'd1);
        chk("t5_mf_idx", mf, 32'h2A5);
        srcpdlptr = 1; #1;
        chk("t5_mf_ptr_wins", mf, 32'h10);
        clr(); #1;
        chk("t5_idle_drv", {31'd0, mfdrive}, 32'd0);
        chk("t5_idle_mf", mf, 32'd0);
        // T6 reset drops pending write and in-flight read
        wr(7, 32'hCAFEF00D);
        do_rst(); state_read = 1; prp = 1; pdla = 10'd5;
        idle();
        chk("t6_pdl_zero", pdl, 32'd0);
        chk("t6_ptr_zero", {22'd0, pdlptr}, 32'd0);
        rd(7); idle();
        n_cmp++;
        if (pdl === 32'hCAFEF00D) begin
            n_err++;
            $display("FAIL t6_lost: got %h, must differ from cafef00d", pdl);
        end

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int ph;
            @(negedge clk); clr();
            ph = $urandom_range(0, 4);
            state_alu   = (ph == 0);
            state_write = (ph == 1);
            state_fetch = (ph == 2);
            state_read  = (ph == 3);
            pdla      = 10'($urandom_range(0, 15));
            pwp       = $urandom_range(0, 1) == 1;
            prp       = $urandom_range(0, 1) == 1;
            pdlcnt    = $urandom_range(0, 1) == 1;
            destpdl_p = $urandom_range(0, 1) == 1;
            destpdlp  = $urandom_range(0, 5) == 0;
            destpdlx  = $urandom_range(0, 5) == 0;
            srcpdlptr = $urandom_range(0, 2) == 0;
            srcpdlidx = $urandom_range(0, 2) == 0;
            ob        = $urandom;
            if (destpdlp && $urandom_range(0, 1) == 1)
                ob[9:0] = $urandom_range(0, 1) == 1 ? 10'h3FF : 10'h000;
            reset     = $urandom_range(0, 99) == 0;
        end
        idle();
        run = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
